reset_sequencer: RTL

//  Generates staged, glitch-free active-low reset_ lines for NUM_STAGES domains of rst_-style cells.

---
 rtl/rst_seq_pkg.sv | 25 ++
 rtl/rst_sync.sv | 19 +
 rtl/reset_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared reset-sequencer types, default timing and counter sizing helper.
// The default timing values are shared with the other domain controllers.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    SYNC,
    HOLD,
    REL,
    DONE,
    ACK
  } state_t;

  localparam int unsigned DEF_NUM_STAGES  = 4;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_HOLD_CYC    = 8;
  localparam int unsigned DEF_GAP_CYC     = 4;

  // Width of a down-counter able to hold max(hold, gap).
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
    int unsigned m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset-deassert synchronizer: asserts asynchronously with rst, releases after STAGES clocks.
module rst_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sync_rst
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '1;
    else     chain <= {chain[STAGES-2:0], 1'b0};
  end

  assign sync_rst = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: holds all domains in reset, then releases them one by one in
// index order, with a software-requested re-sequence and a 4-phase ack handshake.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned GAP_CYC     = DEF_GAP_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  output logic                  sw_rst_ack,
  output logic [NUM_STAGES-1:0] stage_rst_,
  output logic                  seq_done,
  output logic                  busy
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYC, GAP_CYC);
  localparam int unsigned IDX_W = $clog2(NUM_STAGES + 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic                    sw_active;
  logic                    sync_rst;
  logic [NUM_STAGES-1:0]   rel_mask;

  rst_sync #(
    .STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk     (clk),
    .rst     (rst),
    .sync_rst(sync_rst)
  );

  // Released bits accumulate; the next one to release is selected by idx.
  assign rel_mask = stage_rst_ | (NUM_STAGES'(1) << idx);

  // The SYNC->HOLD transition lands one cycle after the synchronizer releases,
  // so the power-on hold count starts one lower than the software one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SYNC;
      cnt        <= '0;
      idx        <= '0;
      sw_active  <= 1'b0;
      stage_rst_ <= '0;
      seq_done   <= 1'b0;
      busy       <= 1'b1;
      sw_rst_ack <= 1'b0;
    end else begin
      case (state)
        SYNC: begin
          if (!sync_rst) begin
            if (HOLD_CYC == 1) begin
              stage_rst_ <= rel_mask;
              idx        <= idx + IDX_W'(1);
              cnt        <= CNT_W'(GAP_CYC - 1);
              state      <= REL;
            end else begin
              cnt   <= CNT_W'(HOLD_CYC - 2);
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            stage_rst_ <= rel_mask;
            idx        <= idx + IDX_W'(1);
            cnt        <= CNT_W'(GAP_CYC - 1);
            state      <= REL;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        REL: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (idx == IDX_W'(NUM_STAGES)) begin
            seq_done <= 1'b1;
            busy     <= 1'b0;
            idx      <= '0;
            if (sw_active) begin
              sw_rst_ack <= 1'b1;
              sw_active  <= 1'b0;
              state      <= ACK;
            end else begin
              state <= DONE;
            end
          end else begin
            stage_rst_ <= rel_mask;
            idx        <= idx + IDX_W'(1);
            cnt        <= CNT_W'(GAP_CYC - 1);
          end
        end
        DONE: begin
          if (sw_rst_req) begin
            stage_rst_ <= '0;
            seq_done   <= 1'b0;
            busy       <= 1'b1;
            idx        <= '0;
            sw_active  <= 1'b1;
            cnt        <= CNT_W'(HOLD_CYC - 1);
            state      <= HOLD;
          end
        end
        ACK: begin
          if (!sw_rst_req) begin
            sw_rst_ack <= 1'b0;
            state      <= DONE;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule
